// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor unit: branch encodings, FSM states and the table entry.
// Table entry widths follow the BPU_INDEX_BITS / BPU_CNT_BITS macros, which also set the top defaults.
`ifndef BPU_INDEX_BITS
`define BPU_INDEX_BITS 10
`endif
`ifndef BPU_CNT_BITS
`define BPU_CNT_BITS 2
`endif

package bpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_CALL = 3'd1,
    BR_RET  = 3'd2,
    BR_BRA  = 3'd3,
    BR_J    = 3'd4
  } br_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_CORRECTION
  } bpu_state_e;

  localparam int unsigned ENTRY_TAG_W = 30 - `BPU_INDEX_BITS;

  typedef struct packed {
    br_type_e                 br_type;
    logic [ENTRY_TAG_W-1:0]   tag;
    logic [31:0]              target;
    logic [`BPU_CNT_BITS-1:0] cnt;
  } bht_entry_t;

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack with checkpoint restore; a push when full overwrites the oldest entry.
// The checkpoint is {ptr, nonempty}; ptr is the next free slot, the top lives at ptr-1.
module bpu_ras #(
  parameter  int RAS_DEPTH = 8,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int PTR_W     = PW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_data,
  input  logic             restore,
  input  logic [PTR_W-1:0] restore_ckpt,
  output logic [PTR_W-1:0] ckpt,
  output logic [31:0]      top,
  output logic             nonempty
);

  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   stack [RAS_DEPTH];
  logic [PW-1:0] ptr_q, base_ptr;
  logic [PW:0]   depth_q, base_depth;

  // The checkpoint only records emptiness, so a restored non-empty stack is treated as full.
  always_comb begin
    base_ptr   = ptr_q;
    base_depth = depth_q;
    if (restore) begin
      base_ptr   = restore_ckpt[PTR_W-1:1];
      base_depth = restore_ckpt[0] ? FULL : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      depth_q <= '0;
    end else if (push) begin
      ptr_q   <= base_ptr + PW'(1);
      depth_q <= (base_depth == FULL) ? FULL : base_depth + (PW+1)'(1);
    end else if (pop && base_depth != '0) begin
      ptr_q   <= base_ptr - PW'(1);
      depth_q <= base_depth - (PW+1)'(1);
    end else begin
      ptr_q   <= base_ptr;
      depth_q <= base_depth;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[base_ptr] <= push_data;
  end

  assign nonempty = (depth_q != '0);
  assign top      = stack[ptr_q - PW'(1)];
  assign ckpt     = {ptr_q, nonempty};

endmodule

// File: rtl/simple_port_ram.sv
// One write port, one read port RAM; LATENCY 0 gives an asynchronous read, otherwise a registered read.
module simple_port_ram #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (LATENCY == 0) begin : g_comb_read
      assign rdata = mem[raddr];
    end else begin : g_reg_read
      always_ff @(posedge clk) begin
        rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/branch_predictor_unit.sv
// Fetch-stage branch predictor: tagged BHT/BTB with saturating counters, checkpointed RAS
// and an IDLE/CORRECTION redirect FSM driven by EX verify results.
module branch_predictor_unit
  import bpu_pkg::*;
#(
  parameter  int INDEX_BITS = `BPU_INDEX_BITS,
  parameter  int CNT_BITS   = `BPU_CNT_BITS,
  parameter  int RAS_DEPTH  = 8,
  localparam int PTR_W      = $clog2(RAS_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush_all,
  input  logic                if_valid,
  input  logic [31:0]         if_pc,
  output logic                pred_valid,
  output logic                pred_br,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [CNT_BITS-1:0] pred_cnt,
  output logic [PTR_W-1:0]    pred_ras_ckpt,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  br_type_e            upd_type,
  input  logic [31:0]         upd_target,
  input  logic                upd_taken,
  input  logic                upd_hit,
  input  logic [CNT_BITS-1:0] upd_cnt,
  input  logic                upd_mispredict,
  input  logic [PTR_W-1:0]    upd_ras_ckpt,
  input  logic                correct_finish,
  output logic                redirect,
  output logic                is_correction,
  output logic [31:0]         correct_target
);

  localparam int ENTRIES = 2**INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK_T = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_WEAK_N = {1'b0, {(CNT_BITS-1){1'b1}}};

  bpu_state_e            state;
  bht_entry_t            rd_entry, wr_entry;
  logic [ENTRIES-1:0]    valid_q;
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic                  hit, wr_en, mis_any, idle, accept;
  logic [CNT_BITS-1:0]   wr_cnt;
  logic [31:0]           if_pc8, upd_pc8, nxt_target, ras_top;
  logic                  nxt_taken, ras_nonempty, ras_push, ras_pop;
  logic                  spec_push, spec_pop;
  logic [PTR_W-1:0]      ras_ckpt;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign rd_idx  = if_pc[INDEX_BITS+1:2];
  assign wr_idx  = upd_pc[INDEX_BITS+1:2];
  assign if_pc8  = if_pc + 32'd8;
  assign upd_pc8 = upd_pc + 32'd8;
  assign hit     = valid_q[rd_idx] && (rd_entry.tag == if_pc[31:INDEX_BITS+2]);
  assign wr_en   = upd_valid && (upd_type != BR_NONE);
  assign mis_any = wr_en && upd_mispredict;
  assign idle    = (state == ST_IDLE);
  assign accept  = mis_any && idle && !flush_all;

  // Counter trains only on a correct hit; anything else restarts it at weak strength.
  always_comb begin
    wr_cnt = upd_taken ? CNT_WEAK_T : CNT_WEAK_N;
    if (upd_hit && !upd_mispredict) begin
      if (upd_taken) wr_cnt = (upd_cnt == CNT_MAX) ? upd_cnt : upd_cnt + CNT_BITS'(1);
      else           wr_cnt = (upd_cnt == '0)      ? upd_cnt : upd_cnt - CNT_BITS'(1);
    end
  end

  always_comb begin
    wr_entry         = '0;
    wr_entry.br_type = upd_type;
    wr_entry.tag     = upd_pc[31:INDEX_BITS+2];
    wr_entry.target  = upd_target;
    wr_entry.cnt     = wr_cnt;
  end

  simple_port_ram #(
    .WIDTH  ($bits(bht_entry_t)),
    .ADDR_W (INDEX_BITS),
    .LATENCY(0)
  ) u_table (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_idx),
    .wdata(wr_entry),
    .raddr(rd_idx),
    .rdata(rd_entry)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  always_comb begin
    nxt_taken  = 1'b0;
    nxt_target = if_pc8;
    if (hit) begin
      case (rd_entry.br_type)
        BR_CALL, BR_J: begin
          nxt_taken  = 1'b1;
          nxt_target = rd_entry.target;
        end
        BR_BRA: if (rd_entry.cnt[CNT_BITS-1]) begin
          nxt_taken  = 1'b1;
          nxt_target = rd_entry.target;
        end
        BR_RET: if (ras_nonempty) begin
          nxt_taken  = 1'b1;
          nxt_target = ras_top;
        end
        default: ;
      endcase
    end
  end

  // Repair of an accepted mispredict wins over this cycle's speculative op.
  assign spec_push = idle && if_valid && hit && (rd_entry.br_type == BR_CALL);
  assign spec_pop  = idle && if_valid && hit && (rd_entry.br_type == BR_RET);
  assign ras_push  = accept ? (upd_type == BR_CALL) : spec_push;
  assign ras_pop   = accept ? (upd_type == BR_RET)  : spec_pop;

  bpu_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .resetn      (resetn),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_data   (accept ? upd_pc8 : if_pc8),
    .restore     (accept),
    .restore_ckpt(upd_ras_ckpt),
    .ckpt        (ras_ckpt),
    .top         (ras_top),
    .nonempty    (ras_nonempty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_valid    <= 1'b0;
      pred_br       <= 1'b0;
      pred_taken    <= 1'b0;
      pred_target   <= '0;
      pred_cnt      <= '0;
      pred_ras_ckpt <= '0;
    end else begin
      pred_valid <= if_valid && hit && idle;
      if (if_valid) begin
        pred_br       <= hit && (rd_entry.br_type != BR_NONE);
        pred_taken    <= nxt_taken;
        pred_target   <= nxt_target;
        pred_cnt      <= hit ? rd_entry.cnt : '0;
        pred_ras_ckpt <= ras_ckpt;
      end
    end
  end

  // Redirect FSM; flush_all returns to IDLE and suppresses the redirect pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      redirect       <= 1'b0;
      correct_target <= '0;
    end else begin
      redirect <= 1'b0;
      if (flush_all) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (mis_any) begin
            state          <= ST_CORRECTION;
            redirect       <= 1'b1;
            correct_target <= upd_taken ? upd_target : upd_pc8;
          end
          ST_CORRECTION: if (correct_finish) state <= ST_IDLE;
        endcase
      end
    end
  end

  assign is_correction = (state == ST_CORRECTION);

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit: counters, RAS push/pop/wrap, repair, FSM, flush and reset.
module tb_branch_predictor_unit;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush_all, if_valid, correct_finish;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic        pred_valid, pred_br, pred_taken, redirect, is_correction;
  logic [31:0] pred_target, correct_target;
  logic [1:0]  pred_cnt, upd_cnt;
  logic [3:0]  pred_ras_ckpt, upd_ras_ckpt;
  logic        upd_valid, upd_taken, upd_hit, upd_mispredict;
  br_type_e    upd_type;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] PC_A = 32'h8000_1000;
  localparam logic [31:0] TG_A = 32'h8000_2000;
  localparam logic [31:0] PC_B = 32'h0000_0500;
  localparam logic [31:0] PC_C = 32'h0000_0600;

  branch_predictor_unit #(.INDEX_BITS(10), .CNT_BITS(2), .RAS_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .flush_all(flush_all),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_br(pred_br), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_cnt(pred_cnt), .pred_ras_ckpt(pred_ras_ckpt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_hit(upd_hit),
    .upd_cnt(upd_cnt), .upd_mispredict(upd_mispredict), .upd_ras_ckpt(upd_ras_ckpt),
    .correct_finish(correct_finish),
    .redirect(redirect), .is_correction(is_correction), .correct_target(correct_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_update(input logic [31:0] pc, input br_type_e t, input logic [31:0] tgt,
                            input logic tk, input logic hit, input logic [1:0] cnt,
                            input logic mis, input logic [3:0] ckpt);
    upd_valid = 1'b1; upd_pc = pc; upd_type = t; upd_target = tgt;
    upd_taken = tk; upd_hit = hit; upd_cnt = cnt; upd_mispredict = mis; upd_ras_ckpt = ckpt;
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input br_type_e t, input logic [31:0] tgt,
                                input logic tk, input logic hit, input logic [1:0] cnt,
                                input logic mis, input logic [3:0] ckpt);
    set_update(pc, t, tgt, tk, hit, cnt, mis, ckpt);
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_valid = 1'b1; if_pc = pc;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush_all = 1'b0; if_valid = 1'b0; if_pc = '0; correct_finish = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_type = BR_NONE; upd_target = '0; upd_taken = 1'b0;
    upd_hit = 1'b0; upd_cnt = '0; upd_mispredict = 1'b0; upd_ras_ckpt = '0;

    // 1: reset state and a miss lookup
    #12;
    check_output("rst_pred_valid", 32'(pred_valid), 32'd0);
    check_output("rst_pred_target", pred_target, 32'd0);
    check_output("rst_redirect", 32'(redirect), 32'd0);
    check_output("rst_is_correction", 32'(is_correction), 32'd0);
    check_output("rst_correct_target", correct_target, 32'd0);
    #1 resetn = 1'b1;
    lookup(32'h0000_1234);
    check_output("miss_pred_valid", 32'(pred_valid), 32'd0);
    check_output("miss_pred_br", 32'(pred_br), 32'd0);
    check_output("miss_pred_target", pred_target, 32'h0000_123C);
    check_output("miss_ras_ckpt", 32'(pred_ras_ckpt), 32'd0);

    // 2: BRA counter training and saturation
    apply_stimulus(PC_A, BR_BRA, TG_A, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0);
    lookup(PC_A);
    check_output("bra_cnt_init", 32'(pred_cnt), 32'd2);
    check_output("bra_valid", 32'(pred_valid), 32'd1);
    check_output("bra_br", 32'(pred_br), 32'd1);
    check_output("bra_taken", 32'(pred_taken), 32'd1);
    check_output("bra_target", pred_target, TG_A);
    apply_stimulus(PC_A, BR_BRA, TG_A, 1'b1, 1'b1, 2'd2, 1'b0, 4'd0);
    lookup(PC_A);
    check_output("bra_cnt_inc", 32'(pred_cnt), 32'd3);
    apply_stimulus(PC_A, BR_BRA, TG_A, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0);
    lookup(PC_A);
    check_output("bra_cnt_sat_hi", 32'(pred_cnt), 32'd3);
    set_update(PC_A, BR_BRA, TG_A, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0);
    lookup(PC_A);
    upd_valid = 1'b0;
    check_output("bra_no_bypass", 32'(pred_cnt), 32'd3);
    lookup(PC_A);
    check_output("bra_cnt_weak_nt", 32'(pred_cnt), 32'd1);
    check_output("bra_nt_taken", 32'(pred_taken), 32'd0);
    check_output("bra_nt_target", pred_target, PC_A + 32'd8);
    apply_stimulus(PC_A, BR_BRA, TG_A, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0);
    lookup(PC_A);
    check_output("bra_cnt_sat_lo", 32'(pred_cnt), 32'd0);
    lookup(32'h8000_5000);
    check_output("tag_miss_valid", 32'(pred_valid), 32'd0);
    check_output("tag_miss_target", pred_target, 32'h8000_5008);

    // 3: CALL/RET pairing, then 9 pushes and 8 pops on an 8-deep stack
    apply_stimulus(32'h100, BR_CALL, 32'h4000, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0);
    apply_stimulus(32'h200, BR_RET, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0);
    lookup(32'h100);
    check_output("call_target", pred_target, 32'h4000);
    check_output("call_ckpt", 32'(pred_ras_ckpt), 32'd0);
    lookup(32'h200);
    check_output("ret_target", pred_target, 32'h108);
    check_output("ret_ckpt", 32'(pred_ras_ckpt), 32'd3);
    lookup(32'h200);
    check_output("ret_empty_taken", 32'(pred_taken), 32'd0);
    check_output("ret_empty_target", pred_target, 32'h208);
    for (int k = 0; k < 9; k++)
      apply_stimulus(32'h300 + 32'(4*k), BR_CALL, 32'h7000, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0);
    for (int k = 0; k < 9; k++) lookup(32'h300 + 32'(4*k));
    for (int j = 0; j < 8; j++) begin
      lookup(32'h200);
      check_output($sformatf("ret_pop_%0d", j), pred_target, 32'h300 + 32'(4*(8-j)) + 32'd8);
    end
    lookup(32'h200);
    check_output("ret_after_drain_taken", 32'(pred_taken), 32'd0);
    check_output("ret_after_drain_ckpt", 32'(pred_ras_ckpt), 32'd2);

    // 4: mispredict repair, redirect pulse and CORRECTION window
    lookup(32'h300);
    lookup(32'h304);
    lookup(32'h308);
    check_output("ckpt_two_entries", 32'(pred_ras_ckpt), 32'd7);
    lookup(32'h30C);
    lookup(32'h310);
    apply_stimulus(PC_B, BR_BRA, 32'h9000, 1'b1, 1'b1, 2'd1, 1'b1, 4'd7);
    check_output("redirect_pulse", 32'(redirect), 32'd1);
    check_output("corr_enter", 32'(is_correction), 32'd1);
    check_output("corr_target", correct_target, 32'h9000);
    tick();
    check_output("redirect_once", 32'(redirect), 32'd0);
    check_output("corr_hold", 32'(is_correction), 32'd1);
    apply_stimulus(PC_B, BR_BRA, 32'h9000, 1'b0, 1'b1, 2'd2, 1'b1, 4'd0);
    check_output("corr_no_redirect", 32'(redirect), 32'd0);
    check_output("corr_target_kept", correct_target, 32'h9000);
    lookup(32'h200);
    check_output("corr_pred_valid", 32'(pred_valid), 32'd0);
    check_output("corr_ras_restored", 32'(pred_ras_ckpt), 32'd7);
    check_output("corr_ras_top", pred_target, 32'h30C);
    lookup(PC_B);
    check_output("corr_table_upd", 32'(pred_cnt), 32'd1);
    correct_finish = 1'b1;
    tick();
    correct_finish = 1'b0;
    check_output("corr_exit", 32'(is_correction), 32'd0);
    lookup(32'h200);
    check_output("idle_ret_valid", 32'(pred_valid), 32'd1);
    check_output("idle_ret_target", pred_target, 32'h30C);

    // 5: flush_all in the same cycle as a mispredict
    flush_all = 1'b1;
    apply_stimulus(PC_C, BR_BRA, 32'hA000, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0);
    flush_all = 1'b0;
    check_output("flush_no_redirect", 32'(redirect), 32'd0);
    check_output("flush_idle", 32'(is_correction), 32'd0);
    lookup(PC_C);
    check_output("flush_tbl_valid", 32'(pred_valid), 32'd1);
    check_output("flush_tbl_cnt", 32'(pred_cnt), 32'd2);
    check_output("flush_tbl_target", pred_target, 32'hA000);

    // 6: asynchronous reset in the middle of CORRECTION
    apply_stimulus(PC_B, BR_BRA, 32'hB000, 1'b1, 1'b1, 2'd1, 1'b1, 4'd0);
    check_output("pre_rst_corr", 32'(is_correction), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_output("async_rst_corr", 32'(is_correction), 32'd0);
    check_output("async_rst_redirect", 32'(redirect), 32'd0);
    check_output("async_rst_target", pred_target, 32'd0);
    check_output("async_rst_ctarget", correct_target, 32'd0);
    #2 resetn = 1'b1;
    lookup(PC_A);
    check_output("post_rst_miss_a", 32'(pred_valid), 32'd0);
    check_output("post_rst_target_a", pred_target, PC_A + 32'd8);
    lookup(32'h100);
    check_output("post_rst_miss_call", 32'(pred_br), 32'd0);
    check_output("post_rst_target_call", pred_target, 32'h108);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
